bridge_sample_reader: RTL

Fabric-side initiator for the SoC's 16-bit external bridge slave port: fetches a block of 16-bit words from SDRAM through the bridge and delivers them, in address order, on a valid/ready sample stream toward the audio output path. It owns the bridge's request side (address, read, byte enable) and consumes acknowledge/read data. One read is outstanding at a time; a small FIFO decouples bridge latency from sample consumption.

---
 rtl/bridge_reader_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/bridge_sample_reader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bridge_reader_pkg.sv
// Shared types and constants for the bridge sample reader.
package bridge_reader_pkg;

    localparam int BRIDGE_AW = 26;
    localparam int BRIDGE_DW = 16;
    localparam logic [1:0] BE_FULL = 2'b11;
    localparam int ADDR_STEP = 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP,
        DRAIN
    } state_t;

    // Bridge words are 16-bit, so byte addresses are always even.
    function automatic logic [BRIDGE_AW-1:0] align_word(input logic [BRIDGE_AW-1:0] addr);
        return addr & ~BRIDGE_AW'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush and occupancy count; head word is visible while non-empty.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is left unreset so it maps to RAM; rd_data is masked to zero while empty instead.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bridge_sample_reader.sv
// Reads a block of 16-bit words over the external bridge and streams them out in address order.
// Optional acknowledge watchdog: define BRIDGE_READER_TIMEOUT_EN.
module bridge_sample_reader
    import bridge_reader_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int CNT_W          = 24,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [25:0]          base_addr,
    input  logic [CNT_W-1:0]     word_count,
    output logic [25:0]          bridge_address,
    output logic [1:0]           bridge_byte_enable,
    output logic                 bridge_read,
    output logic                 bridge_write,
    output logic [15:0]          bridge_write_data,
    input  logic                 bridge_acknowledge,
    input  logic [15:0]          bridge_read_data,
    output logic [15:0]          sample_data,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

    state_t                 state;
    logic [BRIDGE_AW-1:0]   addr;
    logic [CNT_W-1:0]       remaining;
    logic                   stop_pending;
    logic [FIFO_CW-1:0]     fifo_count;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_flush;
    logic                   abort_req;
    logic                   timeout_hit;

`ifdef BRIDGE_READER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             error_q;

    assign timeout_hit = (state == REQ) && !bridge_acknowledge &&
                         (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign error       = error_q;
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    assign bridge_write      = 1'b0;
    assign bridge_write_data = '0;
    assign busy              = (state != IDLE);
    assign sample_valid      = !fifo_empty;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        abort_req  = 1'b0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        fifo_pop   = sample_valid && sample_ready;
        abort_req  = stop || stop_pending;
        // A read acknowledged after an abort is consumed from the bridge but never delivered.
        fifo_push  = (state == REQ) && bridge_acknowledge && !abort_req;
        fifo_flush = (((state == GAP) || (state == DRAIN)) && stop) ||
                     ((state == REQ) && bridge_acknowledge && abort_req) ||
                     timeout_hit;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state              <= IDLE;
            addr               <= '0;
            remaining          <= '0;
            stop_pending       <= 1'b0;
            bridge_read        <= 1'b0;
            bridge_address     <= '0;
            bridge_byte_enable <= '0;
            done               <= 1'b0;
`ifdef BRIDGE_READER_TIMEOUT_EN
            tmo_cnt            <= '0;
            error_q            <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr         <= align_word(base_addr);
                        remaining    <= word_count;
                        stop_pending <= 1'b0;
`ifdef BRIDGE_READER_TIMEOUT_EN
                        error_q      <= 1'b0;
`endif
                        if (word_count == '0) done  <= 1'b1;
                        else                  state <= GAP;
                    end
                end
                GAP: begin
                    if (stop) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (remaining == '0) begin
                        state <= DRAIN;
                    end else if (fifo_count < FIFO_CW'(FIFO_DEPTH)) begin
                        bridge_read        <= 1'b1;
                        bridge_address     <= addr;
                        bridge_byte_enable <= BE_FULL;
                        state              <= REQ;
`ifdef BRIDGE_READER_TIMEOUT_EN
                        tmo_cnt            <= '0;
`endif
                    end
                end
                REQ: begin
                    if (stop) stop_pending <= 1'b1;
                    if (bridge_acknowledge) begin
                        bridge_read        <= 1'b0;
                        bridge_byte_enable <= '0;
                        addr               <= addr + BRIDGE_AW'(ADDR_STEP);
                        remaining          <= remaining - CNT_W'(1);
                        stop_pending       <= 1'b0;
                        if (abort_req) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end
`ifdef BRIDGE_READER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        bridge_read        <= 1'b0;
                        bridge_byte_enable <= '0;
                        stop_pending       <= 1'b0;
                        error_q            <= 1'b1;
                        done               <= 1'b1;
                        state              <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                DRAIN: begin
                    if (stop || fifo_empty) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BRIDGE_DW)
    ) u_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .wr_data (bridge_read_data),
        .rd_data (sample_data),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

endmodule
